idft_conj_seq: RTL and testbench

//  Sequences the conjugate-trick inverse DFT: IDFT(x) = conj(DFT(conj(x)))/N.

---
 rtl/idft_conj_seq.sv | 160 ++++++++++++++++
 tb/tb_idft_conj_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/idft_conj_seq.sv
// ---------------------------------------------------------------------------
// idft_conj_seq
//   Sequencer for the conjugate-trick inverse DFT:
//     IDFT(x) = conj(DFT(conj(x))) / N
//   It owns the shared complex sample RAM (IEEE-754 single precision, with
//   separate real and imaginary words) that sits around an external DFT engine.
//   Inverse request: conjugate the buffer in place, run the DFT, then
//   conjugate and scale the result in place.
//   Forward request: start the DFT engine and relay its completion.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   start, inverse            request pulse (sampled in IDLE only) and mode
//   busy, done                sequence in flight / one-cycle completion pulse
//   mem_addr, mem_rd_en,
//   mem_wr_en, mem_wdata_r/i  RAM port (read data returns one cycle later)
//   mem_rdata_r/i             RAM read data
//   dft_start, dft_done       handshake with the DFT engine
// ---------------------------------------------------------------------------
module idft_conj_seq #(
  parameter int LOG2N = 3,
  parameter bit SCALE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inverse,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] mem_addr,
  output logic             mem_rd_en,
  output logic             mem_wr_en,
  output logic [31:0]      mem_wdata_r,
  output logic [31:0]      mem_wdata_i,
  input  logic [31:0]      mem_rdata_r,
  input  logic [31:0]      mem_rdata_i,
  output logic             dft_start,
  input  logic             dft_done
);

  // Dividing by N = 2**LOG2N amounts to subtracting LOG2N from the exponent.
  localparam logic [7:0] EXP_SHIFT = 8'(LOG2N);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_RD, S_PRE_WR, S_RUN, S_WAIT, S_POST_RD, S_POST_WR, S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic [LOG2N-1:0] k_q, k_d;      // sample counter
  logic             inv_q, inv_d;  // mode captured together with start

  // Negate the imaginary part, folding -0 into +0 so that -0 is never emitted.
  function automatic logic [31:0] conj_im(input logic [31:0] w);
    conj_im = (w[30:0] == 31'd0) ? 32'h0 : {~w[31], w[30:0]};
  endfunction

  // Divide by N: Inf/NaN pass through unchanged; a result that would
  // underflow (including zero and denormal inputs) is flushed to +0.
  function automatic logic [31:0] scale_word(input logic [31:0] w);
    logic [7:0] e;
    e = w[30:23];
    if (e == 8'hFF)           scale_word = w;
    else if (e <= EXP_SHIFT)  scale_word = 32'h0;
    else                      scale_word = {w[31], e - EXP_SHIFT, w[22:0]};
  endfunction

  function automatic logic [31:0] post_word(input logic [31:0] w);
    post_word = SCALE ? scale_word(w) : w;
  endfunction

  // NOTE: combinational block with every output and next-state given a default
  // first, so that no path through the case statement can infer a latch.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    inv_d       = inv_q;
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    mem_addr    = '0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wdata_r = 32'h0;
    mem_wdata_i = 32'h0;
    dft_start   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          inv_d   = inverse;
          k_d     = '0;
          state_d = inverse ? S_PRE_RD : S_RUN;
        end
      end
      S_PRE_RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = k_q;
        state_d   = S_PRE_WR;
      end
      S_PRE_WR: begin
        // Gated by rst so that a write in flight when reset arrives is dropped.
        mem_wr_en   = ~rst;
        mem_addr    = k_q;
        mem_wdata_r = mem_rdata_r;
        mem_wdata_i = conj_im(mem_rdata_i);
        if (&k_q) begin
          k_d     = '0;
          state_d = S_RUN;
        end else begin
          k_d     = k_q + LOG2N'(1);
          state_d = S_PRE_RD;
        end
      end
      S_RUN: begin
        dft_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (dft_done) state_d = inv_q ? S_POST_RD : S_FIN;
      end
      S_POST_RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = k_q;
        state_d   = S_POST_WR;
      end
      S_POST_WR: begin
        mem_wr_en   = ~rst;
        mem_addr    = k_q;
        mem_wdata_r = post_word(mem_rdata_r);
        mem_wdata_i = post_word(conj_im(mem_rdata_i));
        if (&k_q) begin
          k_d     = '0;
          state_d = S_FIN;
        end else begin
          k_d     = k_q + LOG2N'(1);
          state_d = S_POST_RD;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      inv_q   <= inv_d;
    end
  end

endmodule

// File: tb/tb_idft_conj_seq.sv
// ---------------------------------------------------------------------------
// tb_idft_conj_seq
//   Bench for idft_conj_seq with LOG2N=3 and SCALE=1. It provides the sample
//   RAM with one cycle of read latency and an identity DFT engine with a
//   programmable done delay. Expected outputs for each cycle come from the
//   documented cycle schedule of a sequence, and expected write data comes from
//   a snapshot of the RAM taken at start. Literal RAM values pin the model.
// ---------------------------------------------------------------------------
module tb_idft_conj_seq;
  localparam int LOG2N = 3;
  localparam int N     = 8;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, inverse = 1'b0;
  logic busy, done, mem_rd_en, mem_wr_en, dft_start, dft_done;
  logic [LOG2N-1:0] mem_addr;
  logic [31:0] mem_wdata_r, mem_wdata_i;
  logic [31:0] mem_rdata_r = 32'h0, mem_rdata_i = 32'h0;
  logic dft_model = 1'b0, dft_extra = 1'b0;
  assign dft_done = dft_model | dft_extra;

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [31:0] ram_r [N];
  logic [31:0] ram_i [N];

  // Expected-value model state
  bit   chk_en = 1'b0, act = 1'b0, m_inv = 1'b0;
  int   s_cyc = 0, m_lat = 0, dft_lat = 5, pend = -1;
  int   done_cnt = 0, done_cyc = 0;
  logic [31:0] pre_r [N];
  logic [31:0] pre_i [N];
  logic [31:0] fin_r [N];
  logic [31:0] fin_i [N];

  idft_conj_seq #(.LOG2N(LOG2N), .SCALE(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse),
    .busy(busy), .done(done), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata_r(mem_wdata_r), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_r(mem_rdata_r), .mem_rdata_i(mem_rdata_i),
    .dft_start(dft_start), .dft_done(dft_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sample RAM with one cycle of read latency
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata_r <= ram_r[mem_addr];
      mem_rdata_i <= ram_i[mem_addr];
    end
    if (mem_wr_en) begin
      ram_r[mem_addr] <= mem_wdata_r;
      ram_i[mem_addr] <= mem_wdata_i;
    end
  end

  // Identity DFT engine: done is asserted dft_lat cycles after dft_start
  initial forever begin
    @(negedge clk); #1;
    if (dft_start) pend = cyc + dft_lat;
    dft_model = (cyc == pend);
  end

  // Negation of a float; a zero of either sign becomes +0
  function automatic logic [31:0] m_conj(input logic [31:0] w);
    if ((w & 32'h7FFF_FFFF) == 32'h0) return 32'h0;
    return w ^ 32'h8000_0000;
  endfunction

  // Division by 8 on a float word
  function automatic logic [31:0] m_div8(input logic [31:0] w);
    int e;
    e = int'(w[30:23]);
    if (e == 255) return w;
    if (e <= 3)   return 32'h0;
    return w - (32'd3 << 23);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Per-cycle comparison against the documented schedule
  task automatic compare_cycle();
    int t, endt, p;
    logic e_busy, e_done, e_rd, e_wr, e_ds;
    logic [LOG2N-1:0] e_addr;
    logic [31:0] e_r, e_i;
    e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0; e_ds = 0;
    e_addr = '0; e_r = 32'h0; e_i = 32'h0;
    if (act) begin
      t    = cyc - s_cyc;
      endt = m_inv ? 4*N + 2 + m_lat : 2 + m_lat;
      if (t > endt) act = 1'b0;
      else begin
        e_busy = (t >= 1);
        e_done = (t == endt);
        if (m_inv) begin
          if (t >= 1 && t <= 2*N) begin
            p = t - 1;
            e_addr = LOG2N'(p / 2);
            if (p % 2 == 0) e_rd = 1'b1;
            else begin e_wr = 1'b1; e_r = pre_r[p/2]; e_i = pre_i[p/2]; end
          end
          if (t == 2*N + 1) e_ds = 1'b1;
          p = t - (2*N + 2 + m_lat);
          if (p >= 0 && p < 2*N) begin
            e_addr = LOG2N'(p / 2);
            if (p % 2 == 0) e_rd = 1'b1;
            else begin e_wr = 1'b1; e_r = fin_r[p/2]; e_i = fin_i[p/2]; end
          end
        end else if (t == 1) e_ds = 1'b1;
      end
    end
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    check("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
    check("mem_wr_en", 32'(mem_wr_en), 32'(e_wr));
    check("dft_start", 32'(dft_start), 32'(e_ds));
    if (e_rd || e_wr || !e_busy) check("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (e_wr || !e_busy) begin
      check("mem_wdata_r", mem_wdata_r, e_r);
      check("mem_wdata_i", mem_wdata_i, e_i);
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) compare_cycle();
  end

  task automatic load_fill(input logic [31:0] r, input logic [31:0] i);
    for (int k = 0; k < N; k++) begin ram_r[k] <= r; ram_i[k] <= i; end
  endtask

  // Snapshot the RAM into the model and issue a start pulse
  task automatic begin_seq(input logic inv, input int lat);
    @(negedge clk); #1;
    for (int k = 0; k < N; k++) begin
      pre_r[k] = ram_r[k];
      pre_i[k] = m_conj(ram_i[k]);
      fin_r[k] = m_div8(pre_r[k]);
      fin_i[k] = m_div8(m_conj(pre_i[k]));
    end
    m_inv = inv; m_lat = lat; dft_lat = lat; s_cyc = cyc; act = 1'b1;
    start = 1'b1; inverse = inv;
  endtask

  task automatic run_seq(input logic inv, input int lat, input bit poke,
                         input bit chk_pre, input logic [31:0] pre_im, input int exp_len);
    int endt, t, d0;
    d0 = done_cnt;
    begin_seq(inv, lat);
    endt = inv ? 4*N + 2 + lat : 2 + lat;
    for (int i = 0; i < endt + 2; i++) begin
      @(negedge clk); #1;
      t = cyc - s_cyc;
      start = 1'b0; inverse = 1'b0; dft_extra = 1'b0;
      if (poke) begin
        if (t == 3 || t == 2*N + 3) begin start = 1'b1; inverse = ~inv; end
        if (t == 5) dft_extra = 1'b1;
      end
      if (chk_pre && t == 2*N + 1)
        for (int k = 0; k < N; k++) check("pre_pass_im", ram_i[k], pre_im);
    end
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("latency", 32'(done_cyc - s_cyc), 32'(exp_len));
  endtask

  initial begin
    int d_prev;
    for (int k = 0; k < N; k++) begin ram_r[k] <= 32'h0; ram_i[k] <= 32'h0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd", 32'(mem_rd_en), 32'd0);
    check("rst_wr", 32'(mem_wr_en), 32'd0);
    check("rst_dft_start", 32'(dft_start), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata_r", mem_wdata_r, 32'd0);
    check("rst_wdata_i", mem_wdata_i, 32'd0);
    #1 rst = 1'b0; chk_en = 1'b1;

    // 1: inverse on (1.0, 2.0) everywhere, DFT done 5 cycles after start
    load_fill(32'h3F80_0000, 32'h4000_0000);
    run_seq(1'b1, 5, 1'b0, 1'b1, 32'hC000_0000, 39);
    for (int k = 0; k < N; k++) begin
      check("t1_final_re", ram_r[k], 32'h3E00_0000);
      check("t1_final_im", ram_i[k], 32'h3E80_0000);
    end

    // 2: forward request leaves RAM untouched
    run_seq(1'b0, 4, 1'b0, 1'b0, 32'h0, 6);
    check("t2_ram_re", ram_r[3], 32'h3E00_0000);
    check("t2_ram_im", ram_i[3], 32'h3E80_0000);

    // 3/4: conjugate and scale edge cases
    load_fill(32'h4000_0000, 32'h3F80_0000);
    ram_r[0] <= 32'h0180_0000; ram_i[0] <= 32'h0000_0000;
    ram_r[1] <= 32'h0200_0000; ram_i[1] <= 32'h8000_0000;
    ram_r[2] <= 32'h3F80_0000; ram_i[2] <= 32'h7F80_0000;
    run_seq(1'b1, 2, 1'b0, 1'b0, 32'h0, 36);
    check("t3_e3_flush", ram_r[0], 32'h0000_0000);
    check("t3_zero_im", ram_i[0], 32'h0000_0000);
    check("t4_e4_scale", ram_r[1], 32'h0080_0000);
    check("t3_negzero_im", ram_i[1], 32'h0000_0000);
    check("t3_inf_im", ram_i[2], 32'h7F80_0000);
    check("t3_one_re", ram_r[2], 32'h3E00_0000);
    check("t3_fill_re", ram_r[5], 32'h3E80_0000);
    check("t3_fill_im", ram_i[5], 32'h3E00_0000);

    // 5: stray start pulses during PRE and WAIT, stray dft_done during PRE
    load_fill(32'h3F80_0000, 32'h4000_0000);
    run_seq(1'b1, 5, 1'b1, 1'b1, 32'hC000_0000, 39);
    d_prev = done_cnt;
    @(negedge clk); #1 dft_extra = 1'b1;
    @(negedge clk); #1 dft_extra = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_idle_done_count", 32'(done_cnt), 32'(d_prev));

    // 6: reset while in POST_WR at k=4, then a clean sequence
    load_fill(32'h3F80_0000, 32'h4000_0000);
    begin_seq(1'b1, 3);
    for (int i = 0; i < 2*N + 2 + 3 + 9; i++) begin
      @(negedge clk); #1;
      start = 1'b0; inverse = 1'b0;
    end
    rst = 1'b1; act = 1'b0;
    @(negedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_k3_done", ram_i[3], 32'h3E80_0000);
    check("t6_k4_dropped_im", ram_i[4], 32'hC000_0000);
    check("t6_k4_dropped_re", ram_r[4], 32'h3F80_0000);
    run_seq(1'b1, 3, 1'b0, 1'b0, 32'h0, 37);
    check("t6_k0_re", ram_r[0], 32'h3C80_0000);
    check("t6_k0_im", ram_i[0], 32'h3D00_0000);
    check("t6_k4_re", ram_r[4], 32'h3E00_0000);
    check("t6_k4_im", ram_i[4], 32'hBE80_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
